// File: rtl/ripplecarry_seq_ctrl.sv
// Wide adder sequencer: feeds a 4-bit carry-registered ripple slice one nibble
// per 4-cycle phase, chaining carries, with valid/ready on both sides.

module ripplecarry4_clk (
    input  logic       clk,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:1] c_q;

    // NOTE: carry registers carry no reset; the controller holds each nibble
    // for four edges, which overwrites all of them before the sum is sampled.
    always_ff @(posedge clk) begin
        c_q[1] <= (a[0] & b[0]) | (cin    & (a[0] ^ b[0]));
        c_q[2] <= (a[1] & b[1]) | (c_q[1] & (a[1] ^ b[1]));
        c_q[3] <= (a[2] & b[2]) | (c_q[2] & (a[2] ^ b[2]));
    end

    always_comb begin
        sum[0] = a[0] ^ b[0] ^ cin;
        sum[1] = a[1] ^ b[1] ^ c_q[1];
        sum[2] = a[2] ^ b[2] ^ c_q[2];
        sum[3] = a[3] ^ b[3] ^ c_q[3];
        cout   = (a[3] & b[3]) | (c_q[3] & (a[3] ^ b[3]));
    end
endmodule

module ripplecarry_seq_ctrl #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4*NIB-1:0] in_a,
    input  logic [4*NIB-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4*NIB-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);
    localparam int W = 4 * NIB;
    localparam logic [2:0] LAST = 3'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [W-1:0]   op_a, op_b;
    logic           carry;
    logic [1:0]     phase;
    logic [2:0]     idx;
    logic [3:0]     s_sum;
    logic           s_cout;
    logic [W+3:0]   sum_cat;

    ripplecarry4_clk u_slice (
        .clk  (clk),
        .a    (op_a[3:0]),
        .b    (op_b[3:0]),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

    // New nibble enters from the top so nibble k ends at bits [4k+3:4k].
    assign sum_cat = {s_sum, out_sum};

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            busy      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            phase     <= 2'd0;
            idx       <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= in_a;
                        op_b     <= in_b;
                        carry    <= in_cin;
                        phase    <= 2'd0;
                        idx      <= 3'd0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd3) begin
                        out_sum <= sum_cat[W+3:4];
                        carry   <= s_cout;
                        op_a    <= op_a >> 4;
                        op_b    <= op_b >> 4;
                        idx     <= idx + 3'd1;
                        if (idx == LAST) begin
                            out_cout  <= s_cout;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ripplecarry_seq_ctrl.sv
// Self-checking bench: cycle-level transaction model compared every cycle,
// plus directed literal scenarios for latency, backpressure and reset.

module tb_ripplecarry_seq_ctrl;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk, rst_n;
    logic         in_valid, in_ready, in_cin;
    logic [W-1:0] in_a, in_b, out_sum;
    logic         out_valid, out_ready, out_cout, busy;

    ripplecarry_seq_ctrl #(.NIB(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: accept when ready, busy for 4*NIB edges, then hold result.
    bit           m_ok, m_ready, m_valid, m_busy, m_known;
    int           m_cnt;
    logic [W:0]   m_lat;
    logic [W-1:0] m_sum;
    logic         m_cout;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok = 1; m_ready = 1; m_valid = 0; m_busy = 0; m_known = 1;
            m_sum = '0; m_cout = 0; m_cnt = 0;
        end else if (m_ready) begin
            if (in_valid) begin
                m_lat   = {1'b0, in_a} + {1'b0, in_b} + W'(in_cin);
                m_ready = 0; m_busy = 1; m_known = 0; m_cnt = 4 * NIB;
            end
        end else if (!m_valid) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid = 1; m_known = 1;
                m_sum = m_lat[W-1:0]; m_cout = m_lat[W];
            end
        end else if (out_ready) begin
            m_valid = 0; m_busy = 0; m_ready = 1;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("in_ready", in_ready, m_ready);
            check("out_valid", out_valid, m_valid);
            check("busy", busy, m_busy);
            if (m_known) begin
                check("out_sum", out_sum, m_sum);
                check("out_cout", out_cout, m_cout);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 60 && !in_ready; i++) step();
        check("wait in_ready", in_ready, 1);
    endtask

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [W-1:0] exp_sum, input logic exp_cout,
                         input int hold, input bit churn);
        int n;
        wait_ready();
        in_a = a; in_b = b; in_cin = c; in_valid = 1; out_ready = 0;
        step();
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 200) begin
            if (churn) begin
                in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
                in_valid = 1'($urandom); out_ready = 1'($urandom);
            end
            step();
            n++;
        end
        in_valid = 0; out_ready = 0;
        check({name, " latency"}, n, 4 * NIB);
        check({name, " sum"}, out_sum, exp_sum);
        check({name, " cout"}, out_cout, exp_cout);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            step();
            check({name, " held sum"}, out_sum, exp_sum);
            check({name, " held valid"}, out_valid, 1);
            check({name, " held in_ready"}, in_ready, 0);
        end
        in_valid = 0; out_ready = 1;
        step();
        out_ready = 0;
        check({name, " release in_ready"}, in_ready, 1);
        check({name, " release out_valid"}, out_valid, 0);
    endtask

    initial begin
        logic [W:0] r;
        logic [W-1:0] ra, rb;
        logic rc;
        rst_n = 0; in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; out_ready = 0;
        step(); step();
        rst_n = 1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_sum", out_sum, 0);
        check("reset busy", busy, 0);

        do_op("basic", 16'h1234, 16'h4321, 0, 16'h5555, 0, 0, 0);
        do_op("carry chain", 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 0);
        do_op("all ones", 16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1, 0, 0);
        do_op("backpressure", 16'h00FF, 16'h0001, 0, 16'h0100, 0, 5, 0);
        do_op("churn", 16'h8421, 16'h7BDE, 1, 16'h0000, 1, 2, 1);

        // Mid-op reset with simultaneous in_valid
        wait_ready();
        in_a = 16'hABCD; in_b = 16'h1234; in_cin = 1; in_valid = 1;
        step();
        in_valid = 0;
        for (int k = 1; k <= 6; k++) step();
        rst_n = 0; in_valid = 1;
        step();
        rst_n = 1; in_valid = 0;
        check("midrst in_ready", in_ready, 1);
        check("midrst out_valid", out_valid, 0);
        check("midrst out_sum", out_sum, 0);
        check("midrst busy", busy, 0);
        step();
        check("midrst no accept", busy, 0);
        do_op("after reset", 16'h00F0, 16'h0010, 0, 16'h0100, 0, 0, 0);

        // Back-to-back with in_valid held high
        wait_ready();
        in_a = 16'h1111; in_b = 16'h2222; in_cin = 0; in_valid = 1; out_ready = 1;
        step();
        for (int k = 1; k <= 34; k++) begin
            step();
            if (k == 16) check("b2b first out_valid", out_valid, 1);
            if (k == 17) check("b2b in_ready back", in_ready, 1);
            if (k == 18) check("b2b second accept", busy, 1);
            if (k == 34) check("b2b second out_valid", out_valid, 1);
        end
        check("b2b second sum", out_sum, 16'h3333);
        in_valid = 0;
        step();
        out_ready = 0;

        for (int t = 0; t < 20; t++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            r = {1'b0, ra} + {1'b0, rb} + W'(rc);
            do_op("random", ra, rb, rc, r[W-1:0], r[W], $urandom_range(0, 3), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ripplecarry_seq_ctrl.md
# ripplecarry_seq_ctrl

Sequencing controller for the 4-bit carry-registered ripple adder slice `ripplecarry4_clk`, instantiated once inside this block. It accepts wide operand pairs over a valid/ready handshake and feeds the slice one nibble at a time. Each nibble is held for the slice's carry-settle interval, and the nibble carry-out is chained into the next nibble's carry-in. The assembled sum and carry are presented over a valid/ready output handshake. The block sits between an operand source and a result consumer wherever a wide add may trade latency for a single 4-bit datapath.

## Interface
- NIB, default 4: operand width in nibbles. Legal range 1..8. Word width W = 4*NIB.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept; high only in IDLE.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry-in to nibble 0.
- out_valid  output  1  result held on out_sum/out_cout.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  registered sum, (in_a + in_b + in_cin) mod 2^W.
- out_cout  output  1  registered carry-out of the top nibble.
- busy  output  1  high in RUN or DONE.

## Operation
- Reset (rst_n low at an edge): the block returns to IDLE. All outputs and counters are cleared:
  - in_ready=1 after reset
  - out_valid=0, out_sum=0, out_cout=0, busy=0
  - phase=0, nibble index=0
- The slice's internal carry registers have no reset. Correctness comes from the 4-cycle hold, which overwrites all three slice carry registers before any sample.
- FSM states:
  - IDLE: in_ready=1. On an edge with in_valid&in_ready:
    - latch in_a, in_b, in_cin into operand registers
    - clear the nibble index and the phase counter
    - go to RUN
  - RUN: the slice is driven as follows:
    - slice a/b = operand registers bits [3:0]
    - slice cin = latched carry (in_cin for nibble 0; captured slice cout for nibble k>0)
    - a 2-bit phase counter counts 0..3
    - on the edge that ends phase 3, capture the nibble:
      - shift slice sum into out_sum from the MSB side (after NIB captures, nibble k sits at bits [4k+3:4k])
      - latch slice cout as the next carry
      - shift the operand registers right by 4
      - increment the nibble index
    - on the capture of nibble NIB-1, latch out_cout and go to DONE.
  - DONE: out_valid=1. out_sum and out_cout are stable. On an edge with out_ready=1, go to IDLE and clear out_valid. out_sum and out_cout keep their value until the next capture overwrites them.
- Input changes on in_a, in_b, in_cin and in_valid have no effect outside IDLE.
- out_ready is ignored outside DONE.
- There is no IDLE bypass. The edge that leaves DONE does not also accept a new operand.

## Timing
- Accept edge = E. Nibble k is captured at edge E+4(k+1).
- DONE is entered at edge E+4*NIB, so out_valid rises in the cycle after it. For NIB=4 that is E+16.
- Minimum out_ready handshake is edge E+4*NIB+1. The earliest next accept is edge E+4*NIB+2.
- Maximum throughput is one add per 4*NIB+2 cycles.
- Slice timing basis: with operands stable from cycle 0, slice sum[3] and cout are valid after 3 edges. A sample at the 4th edge therefore gives one cycle of margin.
- Backpressure: DONE holds indefinitely while out_ready=0. in_ready stays 0 throughout.
- Reset mid-RUN or mid-DONE: takes effect at that edge. No result is emitted. in_ready=1 in the following cycle.
- Simultaneous in_valid with reset: reset wins, and the operand is not accepted.

## Test plan
- Basic add, NIB=4, 0x1234+0x4321, cin=0, out_ready=1 -> out_valid rises after edge E+16, out_sum=0x5555, out_cout=0. in_ready returns after E+17.
- Full carry chain, 0xFFFF+0x0001, cin=0 -> out_sum=0x0000, out_cout=1. Also 0xFFFF+0xFFFF, cin=1 -> out_sum=0xFFFF, out_cout=1.
- Backpressure, 0x00FF+0x0001 with out_ready=0 for 5 cycles after out_valid -> out_sum=0x0100 stable all 5 cycles, in_ready=0, in_valid pulses ignored. Release -> IDLE next edge.
- Operand churn, in_a/in_b toggled randomly during RUN -> result equals the values latched at E.
- Mid-op reset, rst_n low at E+7 -> all outputs 0 and in_ready=1 next cycle. A following 0x00F0+0x0010 op gives 0x0100 with cout=0, confirming stale slice carries are flushed.
- Back-to-back, two ops with in_valid held high and out_ready=1 -> second accept at E+18, second out_valid after E+34.
